tmds_rx_word_decoder: RTL and testbench
=======================================

// Module: tmds_rx_word_decoder
// PURPOSE
//   Receive-side counterpart of the TMDS transmit gearbox for one HDMI/DVI channel.
//   Deserialises 1 bit/clock at the 10x pixel rate and finds 10-bit word alignment by bit-slipping on control tokens.
//   Decodes each aligned word into 8-bit pixel data, or into a DE=0 control pair.
//   Sits after the channel IBUFDS sampler, one instance per R/G/B lane; slip_count is sized for the board LEDs.
// PARAMETERS
//   LOCK_TOKENS    4     identical consecutive control tokens required to declare lock
//   SEARCH_WINDOW  4096  words without a control token before slip (SEARCH) or loss of lock (LOCKED); >= 2
// PORTS
//   ref_clk      in   1  bit clock (10x pixel clock); single clock domain
//   reset_n      in   1  asynchronous, active-low reset
//   serial_in    in   1  sampled TMDS bit; first bit of each word is q[0]
//   data_out     out  8  decoded pixel byte (valid when word_valid & de)
//   de           out  1  1 = data word, 0 = control token
//   ctrl         out  2  {c1,c0} from last control token; held through data periods
//   word_valid   out  1  1-cycle strobe per decoded word; only while locked
//   locked       out  1  word alignment established
//   slip_count   out  4  wrapping count of bit slips performed (debug)
// BEHAVIOUR
//   Reset: every output 0; shift reg 0; phase 0; state SEARCH; all internal counters 0.
//   Shift: every clock sr <= {serial_in, sr[9:1]}; phase counts 0..9 and wraps.
//   Capture: at phase==9, word q = {serial_in, sr[9:1]}; outputs registered, so word_valid rises the next cycle.
//   Tokens (q[9:0]): 1101010100=00, 0010101011=01, 0101010100=10, 1010101011=11.
//   FSM, evaluated on each captured word:
//     SEARCH : token -> CONFIRM, tok_cnt=1, remember token.
//              non-token -> word_cnt++. When word_cnt reaches SEARCH_WINDOW-1: slip, word_cnt=0.
//     CONFIRM: same token as remembered -> tok_cnt++; at tok_cnt==LOCK_TOKENS -> LOCKED, word_cnt=0.
//              different token -> restart CONFIRM with tok_cnt=1.
//              non-token -> SEARCH, word_cnt=0, no slip.
//     LOCKED : token -> word_cnt=0. Non-token -> word_cnt++.
//              word_cnt reaching SEARCH_WINDOW-1 -> SEARCH with locked=0 on that same cycle, no slip.
//   locked=1 exactly while the state is LOCKED, and is registered with the state.
//   Slip: phase is held (not incremented) for one clock, so the next capture is 1 bit later; slip_count++ (mod 16).
//   Decode, registered with word_valid, only while LOCKED:
//     token    -> de=0, ctrl=token value, data_out=0.
//     non-tok  -> de=1, ctrl holds.
//       d = q[9] ? ~q[7:0] : q[7:0]; data_out[0] = d[0].
//       For i>=1: data_out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
//   Words captured outside LOCKED: word_valid=0; data_out, de and ctrl hold.
//   The word that completes lock is not itself emitted; the first strobe is for the next word.
//   Reset mid-word: alignment is lost and reacquired from SEARCH.
//   The block has no backpressure; a consumer must sample on word_valid.
// TESTING
//   1. Reset mid-stream -> all outputs 0 and locked=0 until a fresh lock sequence.
//   2. Aligned repeating 1101010100 -> locked rises after the 4th word.
//      The next word gives word_valid pulses 10 clocks apart with de=0, ctrl=00; slip_count=0.
//   3. SEARCH_WINDOW=16, token stream offset by 3 bits -> slip_count increments until aligned.
//      Then locked=1 and decoded ctrl=00; no lock on a rotated pattern.
//   4. After lock: 0100000000 -> data_out=0x00, de=1.
//      1011111111 -> data_out=0xFE, de=1. ctrl keeps the last token value.
//   5. After lock, stream 0010101011 -> ctrl=01.
//      Then send SEARCH_WINDOW non-token words: locked falls on the last of them, word_valid stops, slip_count unchanged.
//   6. In CONFIRM, alternate 1101010100 with 0101010100 -> never locks. Insert a data word -> returns to SEARCH.

Source files
------------

// File: rtl/tmds_rx_word_decoder_if.sv
// rtl/tmds_rx_word_decoder_if.sv - serial input and decoded word outputs for one TMDS lane
// master drives the sampled bit and consumes decoded words; slave is the decoder.
interface tmds_rx_word_decoder_if;
  logic       serial_in;
  logic [7:0] data_out;
  logic       de;
  logic [1:0] ctrl;
  logic       word_valid;
  logic       locked;
  logic [3:0] slip_count;

  modport master (
    output serial_in,
    input  data_out, de, ctrl, word_valid, locked, slip_count
  );

  modport slave (
    input  serial_in,
    output data_out, de, ctrl, word_valid, locked, slip_count
  );
endinterface

// File: rtl/tmds_rx_word_decoder.sv
// rtl/tmds_rx_word_decoder.sv - TMDS lane deserialiser with token-based word alignment and decode
// One bit per ref_clk; word boundaries found by slipping until control tokens repeat.
module tmds_rx_word_decoder #(
  parameter int LOCK_TOKENS   = 4,
  parameter int SEARCH_WINDOW = 4096
) (
  input  logic                    ref_clk,
  input  logic                    reset_n,
  tmds_rx_word_decoder_if.slave   rx
);

  localparam int WCW = (SEARCH_WINDOW > 2) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int TCW = $clog2(LOCK_TOKENS + 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(SEARCH_WINDOW - 1);
  localparam logic [TCW-1:0] TOK_LAST  = TCW'(LOCK_TOKENS - 1);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_CONFIRM = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [8:0]     sr_q, sr_d;
  logic [3:0]     phase_q, phase_d;
  logic           hold_q, hold_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [TCW-1:0] tok_cnt_q, tok_cnt_d;
  logic [1:0]     tok_val_q, tok_val_d;
  logic [7:0]     data_q, data_d;
  logic           de_q, de_d;
  logic [1:0]     ctrl_q, ctrl_d;
  logic           valid_q, valid_d;
  logic [3:0]     slip_q, slip_d;

  logic [9:0]     word;
  logic           capture;
  logic           is_tok;
  logic [1:0]     tok_code;
  logic           emit;

  // sr_q holds the nine most recent bits; the current bit completes the word.
  assign word    = {rx.serial_in, sr_q};
  assign capture = (phase_q == 4'd9);

  always_comb begin
    is_tok   = 1'b1;
    tok_code = 2'b00;
    case (word)
      10'b1101010100: tok_code = 2'b00;
      10'b0010101011: tok_code = 2'b01;
      10'b0101010100: tok_code = 2'b10;
      10'b1010101011: tok_code = 2'b11;
      default:        is_tok   = 1'b0;
    endcase
  end

  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] o;
    d    = q[9] ? ~q[7:0] : q[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

  always_comb begin
    state_d    = state_q;
    sr_d       = {rx.serial_in, sr_q[8:1]};
    word_cnt_d = word_cnt_q;
    tok_cnt_d  = tok_cnt_q;
    tok_val_d  = tok_val_q;
    slip_d     = slip_q;
    hold_d     = 1'b0;
    emit       = 1'b0;

    if (capture) begin
      case (state_q)
        S_SEARCH: begin
          if (is_tok) begin
            state_d   = S_CONFIRM;
            tok_cnt_d = TCW'(1);
            tok_val_d = tok_code;
          end else if (word_cnt_q == WORD_LAST) begin
            word_cnt_d = '0;
            hold_d     = 1'b1;
            slip_d     = slip_q + 4'd1;
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
        S_CONFIRM: begin
          if (!is_tok) begin
            state_d    = S_SEARCH;
            word_cnt_d = '0;
          end else if (tok_code != tok_val_q) begin
            tok_cnt_d = TCW'(1);
            tok_val_d = tok_code;
          end else if (tok_cnt_q == TOK_LAST) begin
            state_d    = S_LOCKED;
            word_cnt_d = '0;
          end else begin
            tok_cnt_d = tok_cnt_q + TCW'(1);
          end
        end
        S_LOCKED: begin
          if (is_tok) begin
            word_cnt_d = '0;
            emit       = 1'b1;
          end else if (word_cnt_q == WORD_LAST) begin
            // Lock is dropped on the word itself, so it is never emitted.
            state_d    = S_SEARCH;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
            emit       = 1'b1;
          end
        end
        default: begin
          state_d    = S_SEARCH;
          word_cnt_d = '0;
        end
      endcase
    end

    // A slip stalls the phase counter for one bit, delaying the next capture.
    if (hold_q) begin
      phase_d = phase_q;
    end else if (capture) begin
      phase_d = 4'd0;
    end else begin
      phase_d = phase_q + 4'd1;
    end
  end

  always_comb begin
    data_d  = data_q;
    de_d    = de_q;
    ctrl_d  = ctrl_q;
    valid_d = emit;
    if (emit) begin
      if (is_tok) begin
        de_d   = 1'b0;
        ctrl_d = tok_code;
        data_d = 8'h00;
      end else begin
        de_d   = 1'b1;
        data_d = tmds_decode(word);
      end
    end
  end

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_SEARCH;
      sr_q       <= '0;
      phase_q    <= '0;
      hold_q     <= 1'b0;
      word_cnt_q <= '0;
      tok_cnt_q  <= '0;
      tok_val_q  <= '0;
      data_q     <= '0;
      de_q       <= 1'b0;
      ctrl_q     <= '0;
      valid_q    <= 1'b0;
      slip_q     <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      word_cnt_q <= word_cnt_d;
      tok_cnt_q  <= tok_cnt_d;
      tok_val_q  <= tok_val_d;
      data_q     <= data_d;
      de_q       <= de_d;
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
      slip_q     <= slip_d;
    end
  end

  assign rx.data_out   = data_q;
  assign rx.de         = de_q;
  assign rx.ctrl       = ctrl_q;
  assign rx.word_valid = valid_q;
  assign rx.locked     = (state_q == S_LOCKED);
  assign rx.slip_count = slip_q;

endmodule

// File: tb/tb_tmds_rx_word_decoder.sv
// tb/tb_tmds_rx_word_decoder.sv - directed bench for tmds_rx_word_decoder
// Words are sent q[0] first; outputs sampled 1ns after the rising edge.
module tb_tmds_rx_word_decoder;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] DAT00 = 10'b0100000000;
  localparam logic [9:0] DATFE = 10'b1011111111;
  localparam logic [9:0] DAT11 = 10'b0100001111;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   wv_hits;
  logic wv_last;
  int   tries;

  tmds_rx_word_decoder_if bus ();

  tmds_rx_word_decoder #(
    .LOCK_TOKENS  (4),
    .SEARCH_WINDOW(16)
  ) dut (
    .ref_clk(clk),
    .reset_n(rst_n),
    .rx     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [9:0] w);
    wv_hits = 0;
    wv_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_bit(w[i]);
      wv_last = bus.word_valid;
      if (bus.word_valid) wv_hits++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},   32'(bus.data_out),   32'h0);
    check({tag, "_de"},     32'(bus.de),         32'h0);
    check({tag, "_ctrl"},   32'(bus.ctrl),       32'h0);
    check({tag, "_wv"},     32'(bus.word_valid), 32'h0);
    check({tag, "_locked"}, 32'(bus.locked),     32'h0);
    check({tag, "_slip"},   32'(bus.slip_count), 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.serial_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    do_reset();

    // aligned token stream: lock on the 4th word, first strobe on the 5th
    repeat (3) send_word(TOK00);
    check("lock_before_4th", 32'(bus.locked), 32'h0);
    send_word(TOK00);
    check("lock_after_4th", 32'(bus.locked), 32'h1);
    check("lock_word_not_emitted", 32'(wv_hits), 32'h0);
    send_word(TOK00);
    check("t2_wv_last", 32'(wv_last), 32'h1);
    check("t2_wv_once", 32'(wv_hits), 32'h1);
    check("t2_de", 32'(bus.de), 32'h0);
    check("t2_ctrl", 32'(bus.ctrl), 32'h0);
    check("t2_data", 32'(bus.data_out), 32'h0);
    check("t2_slip", 32'(bus.slip_count), 32'h0);
    send_word(TOK00);
    check("t2_wv_period", 32'(wv_hits), 32'h1);

    // data decode; ctrl holds the last token value
    send_word(TOK11);
    check("t4_ctrl11", 32'(bus.ctrl), 32'h3);
    send_word(DAT00);
    check("t4_d00_data", 32'(bus.data_out), 32'h00);
    check("t4_d00_de", 32'(bus.de), 32'h1);
    check("t4_d00_ctrl", 32'(bus.ctrl), 32'h3);
    send_word(DATFE);
    check("t4_dfe_data", 32'(bus.data_out), 32'hFE);
    check("t4_dfe_wv", 32'(wv_last), 32'h1);
    send_word(DAT11);
    check("t4_d11_data", 32'(bus.data_out), 32'h11);

    // token 01 then a full window of data words drops lock
    send_word(TOK01);
    check("t5_ctrl01", 32'(bus.ctrl), 32'h1);
    check("t5_de0", 32'(bus.de), 32'h0);
    repeat (15) send_word(DAT11);
    check("t5_locked_15", 32'(bus.locked), 32'h1);
    check("t5_wv_15", 32'(wv_last), 32'h1);
    send_word(DAT11);
    check("t5_locked_16", 32'(bus.locked), 32'h0);
    check("t5_wv_16", 32'(wv_hits), 32'h0);
    check("t5_slip", 32'(bus.slip_count), 32'h0);
    check("t5_ctrl_hold", 32'(bus.ctrl), 32'h1);
    send_word(DAT11);
    check("t5_wv_after", 32'(wv_hits), 32'h0);

    // reset mid-word clears everything; relock needs a full sequence
    repeat (4) send_word(TOK00);
    check("t1_relocked", 32'(bus.locked), 32'h1);
    for (int i = 0; i < 4; i++) send_bit(TOK00[i]);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t1_midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) send_word(TOK00);
    check("t1_locked_3", 32'(bus.locked), 32'h0);
    check("t1_ctrl_3", 32'(bus.ctrl), 32'h0);
    send_word(TOK00);
    check("t1_locked_4", 32'(bus.locked), 32'h1);

    // alternating tokens never lock; a data word returns to search
    do_reset();
    repeat (4) begin
      send_word(TOK00);
      send_word(TOK10);
    end
    check("t6_no_lock_alt", 32'(bus.locked), 32'h0);
    send_word(DAT11);
    repeat (3) send_word(TOK10);
    check("t6_search_restart", 32'(bus.locked), 32'h0);
    send_word(TOK10);
    check("t6_lock_after", 32'(bus.locked), 32'h1);
    check("t6_slip", 32'(bus.slip_count), 32'h0);

    // stream offset by 3 bits: slips until aligned, then locks
    do_reset();
    repeat (3) send_bit(1'b0);
    repeat (10) send_word(TOK00);
    check("t3_no_lock_rot", 32'(bus.locked), 32'h0);
    check("t3_no_slip_yet", 32'(bus.slip_count), 32'h0);
    repeat (6) send_word(TOK00);
    check("t3_first_slip", 32'(bus.slip_count), 32'h1);
    check("t3_still_unlocked", 32'(bus.locked), 32'h0);
    tries = 0;
    while (!bus.locked && tries < 100) begin
      send_word(TOK00);
      tries++;
    end
    check("t3_locked", 32'(bus.locked), 32'h1);
    check("t3_slip3", 32'(bus.slip_count), 32'h3);
    send_word(TOK00);
    check("t3_wv", 32'(wv_last), 32'h1);
    check("t3_de", 32'(bus.de), 32'h0);
    check("t3_ctrl", 32'(bus.ctrl), 32'h0);
    check("t3_slip_hold", 32'(bus.slip_count), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
